// File: rtl/uart_tx_sched.sv
// uart_tx_sched: programs the uart (baud, then control) after reset or a reload
// request, then shares the uart TX data register between two byte requesters
// with round-robin arbitration, pacing each write on uart_busy.
module uart_tx_sched #(
    parameter logic [2:0]  REG_DATA     = 3'd0,
    parameter logic [2:0]  REG_CTRL     = 3'd2,
    parameter logic [2:0]  REG_BAUD     = 3'd3,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cfg_baud,
    input  logic [31:0] cfg_ctrl,
    input  logic        cfg_reload,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    input  logic        uart_busy,
    output logic        uart_we,
    output logic [2:0]  uart_reg_num,
    output logic [31:0] uart_wd,
    output logic        init_done,
    output logic        timeout_err,
    output logic        grant_id
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_RST_WAIT  = 3'd0,
        ST_INIT_BAUD = 3'd1,
        ST_INIT_CTRL = 3'd2,
        ST_IDLE      = 3'd3,
        ST_WRITE     = 3'd4,
        ST_WAIT_BUSY = 3'd5,
        ST_WAIT_DONE = 3'd6
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_data;
    logic               r_pend;
    logic               r_we;
    logic [2:0]         r_reg_num;
    logic [31:0]        r_wd;
    logic               r_ready0;
    logic               r_ready1;
    logic               r_init_done;
    logic               r_timeout;
    logic               r_grant;

    state_t             w_state;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [7:0]         w_data;
    logic               w_pend;
    logic               w_we;
    logic [2:0]         w_reg_num;
    logic [31:0]        w_wd;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_init_done;
    logic               w_timeout;
    logic               w_grant;

    // State and registered outputs; reset drops any in-flight byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST_WAIT;
            r_cnt       <= '0;
            r_data      <= '0;
            r_pend      <= 1'b0;
            r_we        <= 1'b0;
            r_reg_num   <= '0;
            r_wd        <= '0;
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_init_done <= 1'b0;
            r_timeout   <= 1'b0;
            r_grant     <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_data      <= w_data;
            r_pend      <= w_pend;
            r_we        <= w_we;
            r_reg_num   <= w_reg_num;
            r_wd        <= w_wd;
            r_ready0    <= w_ready0;
            r_ready1    <= w_ready1;
            r_init_done <= w_init_done;
            r_timeout   <= w_timeout;
            r_grant     <= w_grant;
        end
    end

    // Next state, arbitration, and outputs decoded from the state being entered
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_cnt_inc   = r_cnt + CNT_W'(1);
        w_data      = r_data;
        w_pend      = r_pend | cfg_reload;
        w_init_done = r_init_done;
        w_timeout   = r_timeout;
        w_grant     = r_grant;
        w_we        = 1'b0;
        w_reg_num   = '0;
        w_wd        = '0;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;

        case (r_state)
            ST_RST_WAIT: begin
                w_state = ST_INIT_BAUD;
            end
            ST_INIT_BAUD: begin
                w_state = ST_INIT_CTRL;
            end
            ST_INIT_CTRL: begin
                w_state     = ST_IDLE;
                w_init_done = 1'b1;
            end
            ST_IDLE: begin
                if (r_pend || cfg_reload) begin
                    w_state     = ST_INIT_BAUD;
                    w_pend      = 1'b0;
                    w_init_done = 1'b0;
                    w_timeout   = 1'b0;
                end else if (req0_valid && (!req1_valid || r_grant)) begin
                    w_state = ST_WRITE;
                    w_grant = 1'b0;
                    w_data  = req0_data;
                end else if (req1_valid) begin
                    w_state = ST_WRITE;
                    w_grant = 1'b1;
                    w_data  = req1_data;
                end
            end
            ST_WRITE: begin
                w_state = ST_WAIT_BUSY;
                w_cnt   = CNT_W'(1);
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    w_state = ST_WAIT_DONE;
                end else if (w_cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                    w_state   = ST_IDLE;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    w_state = ST_IDLE;
                end
            end
            default: begin
                w_state = ST_RST_WAIT;
            end
        endcase

        case (w_state)
            ST_INIT_BAUD: begin
                w_we      = 1'b1;
                w_reg_num = REG_BAUD;
                w_wd      = cfg_baud;
            end
            ST_INIT_CTRL: begin
                w_we      = 1'b1;
                w_reg_num = REG_CTRL;
                w_wd      = cfg_ctrl;
            end
            ST_WRITE: begin
                w_we      = 1'b1;
                w_reg_num = REG_DATA;
                w_wd      = {24'b0, w_data};
                w_ready0  = ~w_grant;
                w_ready1  = w_grant;
            end
            default: begin
            end
        endcase
    end

    assign uart_we      = r_we;
    assign uart_reg_num = r_reg_num;
    assign uart_wd      = r_wd;
    assign req0_ready   = r_ready0;
    assign req1_ready   = r_ready1;
    assign init_done    = r_init_done;
    assign timeout_err  = r_timeout;
    assign grant_id     = r_grant;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: init sequence, pacing, round-robin,
// busy timeout, reload and asynchronous reset.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg_baud;
    logic [31:0] cfg_ctrl;
    logic        cfg_reload;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        uart_busy;
    logic        uart_we;
    logic [2:0]  uart_reg_num;
    logic [31:0] uart_wd;
    logic        init_done;
    logic        timeout_err;
    logic        grant_id;

    int n_assert = 0;
    int n_fail   = 0;
    int busy_left = 0;
    bit busy_mode = 1'b0;
    int gap;

    uart_tx_sched #(
        .REG_DATA     (3'd0),
        .REG_CTRL     (3'd2),
        .REG_BAUD     (3'd3),
        .BUSY_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_baud     (cfg_baud),
        .cfg_ctrl     (cfg_ctrl),
        .cfg_reload   (cfg_reload),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .uart_busy    (uart_busy),
        .uart_we      (uart_we),
        .uart_reg_num (uart_reg_num),
        .uart_wd      (uart_wd),
        .init_done    (init_done),
        .timeout_err  (timeout_err),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; uart model raises busy the cycle after a data write, for 4 cycles
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy_left > 0) begin
            uart_busy = 1'b1;
            busy_left--;
        end else begin
            uart_busy = 1'b0;
        end
        if (busy_mode && uart_we && uart_reg_num == 3'd0) busy_left = 4;
    endtask

    task automatic wait_we(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!uart_we && cyc < max);
        chk("wait_we", 32'(uart_we), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_baud   = 32'h7F;
        cfg_ctrl   = 32'h2;
        cfg_reload = 1'b0;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        uart_busy  = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_we",      32'(uart_we),      32'd0);
        chk("rst_reg",     32'(uart_reg_num), 32'd0);
        chk("rst_wd",      uart_wd,           32'd0);
        chk("rst_rdy0",    32'(req0_ready),   32'd0);
        chk("rst_rdy1",    32'(req1_ready),   32'd0);
        chk("rst_init",    32'(init_done),    32'd0);
        chk("rst_tmo",     32'(timeout_err),  32'd0);
        chk("rst_grant",   32'(grant_id),     32'd1);

        // 1: init sequence
        rst_n = 1'b1;
        tick();
        chk("t1_we_baud",  32'(uart_we),      32'd1);
        chk("t1_reg_baud", 32'(uart_reg_num), 32'd3);
        chk("t1_wd_baud",  uart_wd,           32'h7F);
        chk("t1_init0",    32'(init_done),    32'd0);
        tick();
        chk("t1_we_ctrl",  32'(uart_we),      32'd1);
        chk("t1_reg_ctrl", 32'(uart_reg_num), 32'd2);
        chk("t1_wd_ctrl",  uart_wd,           32'h2);
        chk("t1_init0b",   32'(init_done),    32'd0);
        tick();
        chk("t1_we_idle",  32'(uart_we),      32'd0);
        chk("t1_init1",    32'(init_done),    32'd1);

        // 2: single byte paced by busy
        busy_mode  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        tick();
        chk("t2_we",       32'(uart_we),      32'd1);
        chk("t2_reg",      32'(uart_reg_num), 32'd0);
        chk("t2_wd",       uart_wd,           32'h55);
        chk("t2_rdy0",     32'(req0_ready),   32'd1);
        chk("t2_rdy1",     32'(req1_ready),   32'd0);
        chk("t2_grant",    32'(grant_id),     32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h66;
        tick();
        chk("t2_we_off",   32'(uart_we),      32'd0);
        chk("t2_rdy0_off", 32'(req0_ready),   32'd0);
        wait_we(20, gap);
        chk("t2_gap",      32'(gap),          32'd6);
        chk("t2_wd2",      uart_wd,           32'h66);
        chk("t2_rdy1b",    32'(req1_ready),   32'd1);
        chk("t2_grant2",   32'(grant_id),     32'd1);

        // 3: round-robin with both requesters held valid
        req0_valid = 1'b1;
        req0_data  = 8'hA1;
        req1_valid = 1'b1;
        req1_data  = 8'hB2;
        for (int i = 0; i < 4; i++) begin
            wait_we(20, gap);
            chk("t3_gap",   32'(gap),        32'd7);
            chk("t3_wd",    uart_wd,         (i % 2 == 0) ? 32'hA1 : 32'hB2);
            chk("t3_grant", 32'(grant_id),   32'(i % 2));
            chk("t3_rdy0",  32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_rdy1",  32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // 4: busy stuck low -> timeout, later bytes still written
        busy_mode  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h44;
        tick();
        chk("t4_we",       32'(uart_we),     32'd1);
        chk("t4_wd",       uart_wd,          32'h44);
        req0_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t4_tmo_low", 32'(timeout_err), 32'd0);
        end
        tick();
        chk("t4_tmo_high", 32'(timeout_err), 32'd1);
        chk("t4_we_off",   32'(uart_we),     32'd0);
        req1_valid = 1'b1;
        req1_data  = 8'h33;
        tick();
        chk("t4_we2",      32'(uart_we),     32'd1);
        chk("t4_wd2",      uart_wd,          32'h33);
        chk("t4_rdy1",     32'(req1_ready),  32'd1);
        chk("t4_sticky",   32'(timeout_err), 32'd1);
        req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // 5: reload during WAIT_DONE
        busy_mode  = 1'b1;
        cfg_baud   = 32'h1234;
        cfg_ctrl   = 32'h5;
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        tick();
        chk("t5_we",       32'(uart_we),     32'd1);
        chk("t5_wd",       uart_wd,          32'h5A);
        chk("t5_rdy0",     32'(req0_ready),  32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h77;
        tick(); tick(); tick();
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        chk("t5_we_off",   32'(uart_we),     32'd0);
        tick(); tick();
        chk("t5_tmo_kept", 32'(timeout_err), 32'd1);
        chk("t5_init_kept",32'(init_done),   32'd1);
        chk("t5_we_idle",  32'(uart_we),     32'd0);
        tick();
        chk("t5_we_baud",  32'(uart_we),      32'd1);
        chk("t5_reg_baud", 32'(uart_reg_num), 32'd3);
        chk("t5_wd_baud",  uart_wd,           32'h1234);
        chk("t5_init0",    32'(init_done),    32'd0);
        chk("t5_tmo_clr",  32'(timeout_err),  32'd0);
        chk("t5_rdy1_no",  32'(req1_ready),   32'd0);
        tick();
        chk("t5_reg_ctrl", 32'(uart_reg_num), 32'd2);
        chk("t5_wd_ctrl",  uart_wd,           32'h5);
        tick();
        chk("t5_init1",    32'(init_done),    32'd1);
        chk("t5_we_idle2", 32'(uart_we),      32'd0);
        tick();
        chk("t5_we_data",  32'(uart_we),      32'd1);
        chk("t5_wd_data",  uart_wd,           32'h77);
        chk("t5_rdy1",     32'(req1_ready),   32'd1);
        chk("t5_grant",    32'(grant_id),     32'd1);
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // 6: asynchronous reset mid WAIT_DONE
        req0_valid = 1'b1;
        req0_data  = 8'h99;
        tick();
        chk("t6_we",       32'(uart_we),     32'd1);
        chk("t6_wd",       uart_wd,          32'h99);
        req0_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we",   32'(uart_we),     32'd0);
        chk("t6_rst_rdy0", 32'(req0_ready),  32'd0);
        chk("t6_rst_init", 32'(init_done),   32'd0);
        chk("t6_rst_grant",32'(grant_id),    32'd1);
        chk("t6_rst_wd",   uart_wd,          32'd0);
        busy_left = 0;
        uart_busy = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6_we_baud",  32'(uart_we),      32'd1);
        chk("t6_reg_baud", 32'(uart_reg_num), 32'd3);
        chk("t6_wd_baud",  uart_wd,           32'h1234);
        tick();
        chk("t6_reg_ctrl", 32'(uart_reg_num), 32'd2);
        tick();
        chk("t6_init1",    32'(init_done),    32'd1);
        req0_valid = 1'b1;
        tick();
        chk("t6_we_data",  32'(uart_we),      32'd1);
        chk("t6_wd_data",  uart_wd,           32'h99);
        chk("t6_grant",    32'(grant_id),     32'd0);
        req0_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
